// File: rtl/program_loader.sv
// Boot loader: fills the CPU RAM from the external pins, one byte per strobe,
// owning the shared bus and MAR/RAM strobes and holding the CPU in reset until done.
module program_loader #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  wr_strobe,
  input  logic                  stop,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] bus_out,
  output logic                  bus_oe,
  output logic                  n_load_addr,
  output logic                  n_load_data,
  output logic                  n_ce,
  output logic                  n_lr,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BYTE,
    S_ADDR,
    S_DATA,
    S_WRITE,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            start_sync_q, strobe_sync_q, stop_sync_q;
  logic                  start_prev_q, strobe_prev_q;
  logic                  start_edge_q, strobe_edge_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] byte_q, byte_d;
  logic                  overrun_q, overrun_d;
  logic                  cpu_hold_q;
  logic                  stop_s;

  assign stop_s = stop_sync_q[1];

  // Two-flop synchronizers, a third flop for edge detection, and a registered edge pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_sync_q  <= '0;
      strobe_sync_q <= '0;
      stop_sync_q   <= '0;
      start_prev_q  <= 1'b0;
      strobe_prev_q <= 1'b0;
      start_edge_q  <= 1'b0;
      strobe_edge_q <= 1'b0;
    end else begin
      start_sync_q  <= {start_sync_q[0], start};
      strobe_sync_q <= {strobe_sync_q[0], wr_strobe};
      stop_sync_q   <= {stop_sync_q[0], stop};
      start_prev_q  <= start_sync_q[1];
      strobe_prev_q <= strobe_sync_q[1];
      start_edge_q  <= start_sync_q[1] & ~start_prev_q;
      strobe_edge_q <= strobe_sync_q[1] & ~strobe_prev_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      byte_q     <= '0;
      overrun_q  <= 1'b0;
      cpu_hold_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      byte_q     <= byte_d;
      overrun_q  <= overrun_d;
      cpu_hold_q <= (state_d != S_DONE);
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    byte_d      = byte_q;
    overrun_d   = overrun_q;
    bus_out     = '0;
    bus_oe      = 1'b0;
    n_load_addr = 1'b1;
    n_load_data = 1'b1;
    n_ce        = 1'b1;
    n_lr        = 1'b1;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_edge_q) begin
          state_d   = S_WAIT_BYTE;
          addr_d    = '0;
          overrun_d = 1'b0;
        end
      end
      S_WAIT_BYTE: begin
        // stop wins over a coincident strobe; that byte is dropped
        if (stop_s) begin
          state_d = S_DONE;
        end else if (strobe_edge_q) begin
          byte_d  = data_in;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        bus_out     = DATA_WIDTH'(addr_q);
        bus_oe      = 1'b1;
        n_load_addr = 1'b0;
        state_d     = S_DATA;
        if (strobe_edge_q) overrun_d = 1'b1;
      end
      S_DATA: begin
        bus_out     = byte_q;
        bus_oe      = 1'b1;
        n_load_data = 1'b0;
        state_d     = S_WRITE;
        if (strobe_edge_q) overrun_d = 1'b1;
      end
      S_WRITE: begin
        n_ce   = 1'b0;
        n_lr   = 1'b0;
        addr_d = addr_q + ADDR_WIDTH'(1);
        if (addr_q == {ADDR_WIDTH{1'b1}}) state_d = S_DONE;
        else                              state_d = S_WAIT_BYTE;
        if (strobe_edge_q) overrun_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign cpu_hold = cpu_hold_q;
  assign addr     = addr_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: a scoreboard queue of {addr, byte} per strobe
// is checked against the bus during the address/data phases.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, wr_strobe, stop;
  logic [7:0] data_in;
  logic [7:0] bus_out;
  logic       bus_oe, n_load_addr, n_load_data, n_ce, n_lr;
  logic       cpu_hold, busy, overrun;
  logic [3:0] addr;

  int         n_pass  = 0;
  int         n_total = 0;
  int         writes  = 0;
  logic [3:0] exp_addr = 4'h0;
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  program_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .wr_strobe(wr_strobe), .stop(stop),
    .data_in(data_in), .bus_out(bus_out), .bus_oe(bus_oe),
    .n_load_addr(n_load_addr), .n_load_data(n_load_data), .n_ce(n_ce), .n_lr(n_lr),
    .cpu_hold(cpu_hold), .busy(busy), .addr(addr), .overrun(overrun)
  );

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (n_load_addr === 1'b0) begin
        n_total++;
        if (exp_q.size() == 0)
          $display("FAIL sb_addr: address phase with empty scoreboard, bus_out=%h", bus_out);
        else if (bus_out !== {4'h0, exp_q[0][11:8]} || bus_oe !== 1'b1 || n_load_data !== 1'b1)
          $display("FAIL sb_addr: bus_out=%h oe=%b nlmd=%b, want %h oe=1 nlmd=1",
                   bus_out, bus_oe, n_load_data, {4'h0, exp_q[0][11:8]});
        else n_pass++;
      end
      if (n_load_data === 1'b0) begin
        logic [11:0] e;
        n_total++;
        if (exp_q.size() == 0)
          $display("FAIL sb_data: data phase with empty scoreboard, bus_out=%h", bus_out);
        else begin
          e = exp_q.pop_front();
          if (bus_out !== e[7:0] || bus_oe !== 1'b1 || n_load_addr !== 1'b1)
            $display("FAIL sb_data: bus_out=%h oe=%b, want %h oe=1", bus_out, bus_oe, e[7:0]);
          else n_pass++;
        end
      end
      if (n_lr === 1'b0) begin
        writes++;
        n_total++;
        if (n_ce !== 1'b0 || bus_oe !== 1'b0)
          $display("FAIL sb_write: n_ce=%b bus_oe=%b, want 0 0", n_ce, bus_oe);
        else n_pass++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(2);
    start = 1'b0;
    tick(6);
  endtask

  task automatic send_byte(input logic [7:0] d, input bit push);
    if (push) begin
      exp_q.push_back({exp_addr, d});
      exp_addr++;
    end
    data_in   = d;
    wr_strobe = 1'b1;
    tick(2);
    wr_strobe = 1'b0;
    tick(8);
  endtask

  task automatic check_done(input logic [3:0] want_addr, input logic want_ovr, input string nm);
    n_total++;
    if (cpu_hold !== 1'b0 || busy !== 1'b0 || addr !== want_addr || overrun !== want_ovr || bus_oe !== 1'b0)
      $display("FAIL %s: hold=%b busy=%b addr=%h ovr=%b oe=%b, want 0 0 %h %b 0",
               nm, cpu_hold, busy, addr, overrun, bus_oe, want_addr, want_ovr);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; wr_strobe = 1'b0; stop = 1'b0; data_in = 8'h00;
    tick(3);
    n_total++;
    if (cpu_hold !== 1'b1 || busy !== 1'b0 || addr !== 4'h0 || overrun !== 1'b0)
      $display("FAIL reset_status: hold=%b busy=%b addr=%h ovr=%b, want 1 0 0 0", cpu_hold, busy, addr, overrun);
    else n_pass++;
    n_total++;
    if (bus_oe !== 1'b0 || bus_out !== 8'h00 || n_load_addr !== 1'b1 || n_load_data !== 1'b1 ||
        n_ce !== 1'b1 || n_lr !== 1'b1)
      $display("FAIL reset_bus: oe=%b out=%h strobes=%b%b%b%b, want 0 00 1111",
               bus_oe, bus_out, n_load_addr, n_load_data, n_ce, n_lr);
    else n_pass++;
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_full_load();
    int w0;
    pulse_start();
    exp_addr = 4'h0;
    n_total++;
    if (busy !== 1'b1 || cpu_hold !== 1'b1 || addr !== 4'h0)
      $display("FAIL full_start: busy=%b hold=%b addr=%h, want 1 1 0", busy, cpu_hold, addr);
    else n_pass++;
    w0 = writes;
    for (int i = 0; i < 16; i++) begin
      send_byte(8'h10 + 8'(i), 1'b1);
      if (i == 7) begin
        n_total++;
        if (addr !== 4'h8 || cpu_hold !== 1'b1)
          $display("FAIL full_mid: addr=%h hold=%b, want 8 1", addr, cpu_hold);
        else n_pass++;
      end
    end
    check_done(4'h0, 1'b0, "full_done");
    n_total++;
    if (writes - w0 !== 16) $display("FAIL full_writes: got %0d, want 16", writes - w0);
    else n_pass++;
  endtask

  task automatic test_reload();
    int k;
    start = 1'b1;
    k = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 2) start = 1'b0;
      if (cpu_hold === 1'b1 && k == 0) begin
        k = c;
        n_total++;
        if (busy !== 1'b1 || addr !== 4'h0)
          $display("FAIL reload_state: busy=%b addr=%h, want 1 0", busy, addr);
        else n_pass++;
      end
    end
    tick(1);
    n_total++;
    if (k != 4) $display("FAIL reload_hold_cycle: got %0d, want 4", k);
    else n_pass++;
    exp_addr = 4'h0;
    send_byte(8'h3C, 1'b1);
    pulse_start();
    n_total++;
    if (addr !== 4'h1 || busy !== 1'b1 || cpu_hold !== 1'b1)
      $display("FAIL start_in_wait: addr=%h busy=%b hold=%b, want 1 1 1", addr, busy, cpu_hold);
    else n_pass++;
  endtask

  task automatic test_latency();
    int ta, td, tw;
    ta = -1; td = -1; tw = -1;
    exp_q.push_back({exp_addr, 8'hC5});
    exp_addr++;
    data_in   = 8'hC5;
    wr_strobe = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 2) wr_strobe = 1'b0;
      if (n_load_addr === 1'b0 && ta < 0) ta = c;
      if (n_load_data === 1'b0 && td < 0) td = c;
      if (n_lr === 1'b0 && tw < 0) tw = c;
    end
    tick(1);
    n_total++;
    if (ta != 4 || td != 5 || tw != 6)
      $display("FAIL latency: addr/data/write at %0d/%0d/%0d, want 4/5/6", ta, td, tw);
    else n_pass++;
  endtask

  task automatic test_early_stop();
    int w0;
    stop = 1'b1;
    tick(6);
    check_done(4'h2, 1'b0, "stop_from_wait");
    stop = 1'b0;
    tick(2);
    pulse_start();
    exp_addr = 4'h0;
    for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i), 1'b1);
    stop = 1'b1;
    tick(6);
    check_done(4'h5, 1'b0, "early_stop");
    w0 = writes;
    send_byte(8'hEE, 1'b0);
    n_total++;
    if (writes != w0 || overrun !== 1'b0 || addr !== 4'h5)
      $display("FAIL done_ignores_strobe: writes+%0d ovr=%b addr=%h, want 0 0 5", writes - w0, overrun, addr);
    else n_pass++;
    stop = 1'b0;
    tick(2);
  endtask

  task automatic test_overrun();
    int w0;
    pulse_start();
    exp_addr = 4'h0;
    w0 = writes;
    exp_q.push_back({exp_addr, 8'h55});
    exp_addr++;
    data_in   = 8'h55;
    wr_strobe = 1'b1; tick(1);
    wr_strobe = 1'b0; tick(1);
    wr_strobe = 1'b1; tick(1);
    wr_strobe = 1'b0; tick(10);
    n_total++;
    if (overrun !== 1'b1 || addr !== 4'h1 || writes - w0 != 1)
      $display("FAIL overrun: ovr=%b addr=%h writes+%0d, want 1 1 1", overrun, addr, writes - w0);
    else n_pass++;
    send_byte(8'h66, 1'b1);
    stop = 1'b1;
    tick(6);
    check_done(4'h2, 1'b1, "overrun_sticky");
    stop = 1'b0;
    tick(2);
    pulse_start();
    n_total++;
    if (overrun !== 1'b0 || addr !== 4'h0)
      $display("FAIL overrun_clear: ovr=%b addr=%h, want 0 0", overrun, addr);
    else n_pass++;
    exp_addr = 4'h0;
  endtask

  task automatic test_reset_mid();
    bit seen;
    int w0;
    seen = 1'b0;
    exp_q.push_back({exp_addr, 8'h99});
    data_in   = 8'h99;
    wr_strobe = 1'b1;
    for (int c = 1; c <= 15 && !seen; c++) begin
      @(negedge clk);
      if (c == 2) wr_strobe = 1'b0;
      if (n_load_data === 1'b0) seen = 1'b1;
    end
    wr_strobe = 1'b0;
    n_total++;
    if (!seen) $display("FAIL reset_mid_reach: data phase not seen within 15 clk");
    else n_pass++;
    w0 = writes;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (bus_oe !== 1'b0 || n_load_addr !== 1'b1 || n_load_data !== 1'b1 || n_ce !== 1'b1 ||
        n_lr !== 1'b1 || addr !== 4'h0 || busy !== 1'b0 || cpu_hold !== 1'b1)
      $display("FAIL reset_mid: oe=%b strobes=%b%b%b%b addr=%h busy=%b hold=%b, want 0 1111 0 0 1",
               bus_oe, n_load_addr, n_load_data, n_ce, n_lr, addr, busy, cpu_hold);
    else n_pass++;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    n_total++;
    if (writes != w0) $display("FAIL reset_mid_nowrite: writes+%0d, want 0", writes - w0);
    else n_pass++;
    pulse_start();
    exp_addr = 4'h0;
    send_byte(8'h77, 1'b1);
    n_total++;
    if (addr !== 4'h1 || busy !== 1'b1)
      $display("FAIL reset_reload: addr=%h busy=%b, want 1 1", addr, busy);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_reload();
    test_latency();
    test_early_stop();
    test_overrun();
    test_reset_mid();
    tick(4);
    n_total++;
    if (exp_q.size() != 0) $display("FAIL sb_drain: %0d entries left, want 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
